// File: rtl/rdat_line_fifo_pkg.sv
// Shared bus-logic constants for the read/write channel managers and the
// read-data line FIFO that sits behind the read channel manager.
package rdat_line_fifo_pkg;

    // Width of one assembled read line.
    localparam int LINE_W   = 128;

    // Default line FIFO geometry; RQ_AW must equal log2(RQ_DEPTH).
    localparam int RQ_DEPTH = 4;
    localparam int RQ_AW    = 2;

    typedef logic [LINE_W-1:0] line_t;

    // True when n is a power of two and at least 2.
    function automatic bit depth_ok(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/rdat_fifo_ptr.sv
// Pointer, occupancy and overflow bookkeeping for the read-data line FIFO.
// Every output apart from push/pop is decoded from registered state only,
// so rqfull_1 and line_valid have no combinational path from any input.
module rdat_fifo_ptr
    import rdat_line_fifo_pkg::*;
#(
    parameter int DEPTH = RQ_DEPTH,
    parameter int AW    = RQ_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic          rd_ready,
    input  logic          ovf_clr,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count,
    output logic          line_valid,
    output logic          rqfull_1,
    output logic          ovf_err
);

    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - 1);

    logic overflow;

    // A pop frees a slot in the same cycle, so a push is still accepted when
    // the FIFO is full and the head is being consumed.
    always_comb begin
        line_valid = (count != '0);
        pop        = line_valid && rd_ready;
        push       = wr_valid && ((count < FULL_CNT) || pop);
        overflow   = wr_valid && !push;
        rqfull_1   = (count >= AFULL_CNT);
    end

    // Pointers wrap naturally because DEPTH is a power of two; an overflow
    // wins over a simultaneous clear so no drop event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (overflow)     ovf_err <= 1'b1;
            else if (ovf_clr) ovf_err <= 1'b0;
        end
    end

endmodule

// File: rtl/rdat_line_fifo.sv
// Read-data line FIFO: buffers assembled 128-bit read lines from the read
// data channel manager and presents them first-word fall-through to the
// consumer. rqfull_1 is an almost-full flag that feeds the manager's
// rqfull_1 input directly, giving it one cycle of slack to stop pushing.
module rdat_line_fifo
    import rdat_line_fifo_pkg::*;
#(
    parameter int DEPTH = RQ_DEPTH,
    parameter int AW    = RQ_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] rdat_m_data,
    input  logic              rdat_m_valid,
    output logic              rqfull_1,
    output logic              line_valid,
    input  logic              line_ready,
    output logic [LINE_W-1:0] line_data,
    output logic [AW:0]       rq_level,
    output logic              ovf_err,
    input  logic              ovf_clr
);

    line_t         mem [DEPTH];
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    rdat_fifo_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (rdat_m_valid),
        .rd_ready   (line_ready),
        .ovf_clr    (ovf_clr),
        .push       (push),
        .pop        (pop),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .count      (count),
        .line_valid (line_valid),
        .rqfull_1   (rqfull_1),
        .ovf_err    (ovf_err)
    );

    // Line storage is deliberately left unreset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rdat_m_data;
    end

    // Head entry is read straight from the array, so a fresh write becomes
    // visible exactly one cycle later and never bypasses to the output.
    always_comb begin
        line_data = mem[rd_ptr];
        rq_level  = count;
    end

endmodule

// File: doc/rdat_line_fifo.md
RDAT_LINE_FIFO -- requirements
Module: rdat_line_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of 128-bit line entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter AW, default 2, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rdat_m_data  input  128  assembled read line from the read data channel manager.
REQ-006 rdat_m_valid  input  1  one-cycle push strobe for rdat_m_data.
REQ-007 rqfull_1  output  1  almost-full back-pressure to the read data channel manager.
REQ-008 line_valid  output  1  head entry available to the consumer.
REQ-009 line_ready  input  1  consumer accepts the head entry.
REQ-010 line_data  output  128  head entry data.
REQ-011 rq_level  output  AW+1  current occupancy, 0..DEPTH.
REQ-012 ovf_err  output  1  sticky overflow flag.
REQ-013 ovf_clr  input  1  synchronous clear of ovf_err.

Function
REQ-014 Storage: DEPTH x 128 register array; wr_ptr and rd_ptr of AW bits, wrapping DEPTH-1 -> 0; count of AW+1 bits.
REQ-015 push = rdat_m_valid and (count < DEPTH or pop); a push writes rdat_m_data at wr_ptr and increments wr_ptr.
REQ-016 pop = line_valid and line_ready; a pop increments rd_ptr.
REQ-017 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-018 Push and pop in the same cycle at count=DEPTH: both SHALL take effect; count stays DEPTH.
REQ-019 Push at count=0 with line_ready high: no bypass; the entry SHALL become visible on line_valid the next cycle. Write-to-read latency is exactly 1 cycle.
REQ-020 line_valid = (count != 0); line_data = array[rd_ptr] (first-word fall-through, combinational from registered state).
REQ-021 line_data SHALL remain stable while line_valid is high and line_ready is low.
REQ-022 rqfull_1 = (count >= DEPTH-1), registered-state derived with no combinational path from inputs.
REQ-023 rdat_m_valid at count=DEPTH without pop: data SHALL be dropped, pointers and count unchanged, and ovf_err set the next cycle.
REQ-024 ovf_err SHALL hold until ovf_clr is sampled high; an overflow and ovf_clr in the same cycle leaves ovf_err set.
REQ-025 rq_level = count.
REQ-026 Pop at count=0 is impossible by construction (line_valid low); line_ready is ignored when empty.

Reset
REQ-027 On rst_n low, asynchronously: wr_ptr=0, rd_ptr=0, count=0, ovf_err=0; hence line_valid=0, rqfull_1=0, rq_level=0.
REQ-028 Array contents are not reset; line_data is don't-care while line_valid=0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; the first post-reset push lands in entry 0.

Structure
REQ-030 DEPTH/AW defaults and the 128-bit line width constant belong in the shared bus-logic package used by the read/write channel managers.
REQ-031 One sub-module: rdat_fifo_ptr (pointer/count/flag logic); the data array stays in the top.
REQ-032 Block SHALL instantiate alongside read_channels_mngr, with rqfull_1 wired directly to its rqfull_1 input.

Verification
REQ-033 Reset, then push 0x...0001..0x...0003 on 3 consecutive cycles, line_ready=0 -> rq_level=3, rqfull_1=1 after the third push, line_data=0x...0001.
REQ-034 Fill to 4, then push with line_ready=1 in the same cycle -> the 0x...0001 pop and the new push are both accepted, rq_level stays 4, ovf_err=0.
REQ-035 At count=4, push 0xDEAD with line_ready=0 -> data dropped, ovf_err=1 next cycle; drained order 1,2,3,4; ovf_clr pulse -> ovf_err=0.
REQ-036 Push on the cycle after reset release with line_ready=1 -> line_valid rises 1 cycle later, pops the same cycle, rq_level returns to 0.
REQ-037 Stream 10 pushes at 1/cycle with line_ready=1 continuously -> output order 1..10 with no loss; pointers wrap twice.
REQ-038 Assert rst_n low with count=3 -> line_valid=0 and rq_level=0 immediately; the next push is read back from entry 0.
